// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Stall/flush sequencer for a 5-stage RISC-V pipeline.
//           Covers load-use stalls, taken-branch flushes and data-memory waits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 15,
  parameter int WAIT_W       = 4,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             START,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             Ctrl_Mux_DE,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEM_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_FLUSH    = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t              r_state, w_next_state;
  logic [WAIT_W-1:0]   r_wait_cnt, w_next_wait;
  logic [FLUSH_W-1:0]  r_flush_cnt, w_next_flush;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_mem_wait;
  logic w_load_use;
  logic w_stall;

  assign w_mem_wait = MEM_req & ~MEM_ready;
  assign w_load_use = EX_MemRead & (EX_Rd != 5'd0) &
                      ((EX_Rd == ID_Rs1) | (ID_uses_rs2 & (EX_Rd == ID_Rs2)));

  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_next_flush = r_flush_cnt;
    PC_en        = 1'b0;
    IFID_en      = 1'b0;
    IFID_flush   = 1'b0;
    Ctrl_Mux_DE  = 1'b0;
    IDEX_en      = 1'b0;
    EXMEM_en     = 1'b0;

    if (EN) begin
      case (r_state)
        S_IDLE: begin
          if (START) w_next_state = S_RUN;
        end

        S_RUN: begin
          if (w_mem_wait) begin
            Ctrl_Mux_DE  = 1'b1;
            w_next_wait  = WAIT_W'(1);
            w_next_state = S_MEM_WAIT;
          end else if (EX_branch_taken) begin
            PC_en      = 1'b1;
            IFID_en    = 1'b1;
            IFID_flush = 1'b1;
            IDEX_en    = 1'b1;
            EXMEM_en   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_next_flush = FLUSH_W'(FLUSH_CYCLES - 1);
              w_next_state = S_FLUSH;
            end
          end else if (w_load_use) begin
            IDEX_en  = 1'b1;
            EXMEM_en = 1'b1;
          end else begin
            PC_en       = 1'b1;
            IFID_en     = 1'b1;
            Ctrl_Mux_DE = 1'b1;
            IDEX_en     = 1'b1;
            EXMEM_en    = 1'b1;
          end
        end

        S_FLUSH: begin
          // A memory wait suspends the flush; flush_cnt resumes afterwards.
          if (w_mem_wait) begin
            Ctrl_Mux_DE  = 1'b1;
            w_next_wait  = WAIT_W'(1);
            w_next_state = S_MEM_WAIT;
          end else begin
            PC_en      = 1'b1;
            IFID_en    = 1'b1;
            IFID_flush = 1'b1;
            IDEX_en    = 1'b1;
            EXMEM_en   = 1'b1;
            if (r_flush_cnt <= FLUSH_W'(1)) begin
              w_next_flush = '0;
              w_next_state = S_RUN;
            end else begin
              w_next_flush = r_flush_cnt - FLUSH_W'(1);
            end
          end
        end

        S_MEM_WAIT: begin
          Ctrl_Mux_DE = 1'b1;
          if (MEM_ready) begin
            w_next_wait  = '0;
            w_next_state = (r_flush_cnt != '0) ? S_FLUSH : S_RUN;
          end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
            w_next_state = S_ERROR;
          end else begin
            w_next_wait = r_wait_cnt + WAIT_W'(1);
          end
        end

        S_ERROR: begin
        end

        default: w_next_state = S_IDLE;
      endcase
    end
  end

  assign w_stall = EN & ((r_state == S_RUN) | (r_state == S_FLUSH) |
                         (r_state == S_MEM_WAIT)) & (~PC_en | ~Ctrl_Mux_DE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_flush_cnt <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= w_next_wait;
      r_flush_cnt <= w_next_flush;
      if (w_next_state == S_ERROR) r_timeout <= 1'b1;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign MEM_timeout = r_timeout;
  assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire
